// File: rtl/readout_sequencer_if.sv
// Handshake bundle between the trigger manager / channel engines and the readout sequencer.
// Carries the start request, the per-channel req/done grants and the status outputs.
// Modports: master = trigger manager plus channel engines, slave = readout_sequencer.
interface readout_sequencer_if #(
  parameter int NUM_CHAN = 5,
  parameter int FILL_W   = 24
);
  // Trigger-manager side
  logic                start;
  logic [FILL_W-1:0]   fill_num;
  logic [NUM_CHAN-1:0] chan_en;
  // Channel engine side
  logic [NUM_CHAN-1:0] chan_done;
  logic [NUM_CHAN-1:0] chan_req;
  // Status
  logic [2:0]          cur_chan;
  logic [FILL_W-1:0]   cur_fill;
  logic                busy;
  logic                readout_done;
  logic [NUM_CHAN-1:0] err_mask;

  modport master (
    output start, fill_num, chan_en, chan_done,
    input  chan_req, cur_chan, cur_fill, busy, readout_done, err_mask
  );

  modport slave (
    input  start, fill_num, chan_en, chan_done,
    output chan_req, cur_chan, cur_fill, busy, readout_done, err_mask
  );
endinterface

// File: rtl/readout_sequencer.sv
// Grants readout to each enabled channel in turn (lowest index first) after a fill is stored.
// Ports: clk, reset (sync, active-high), bus (slave modport: start/fill_num/chan_en/chan_done in;
//        chan_req/cur_chan/cur_fill/busy/readout_done/err_mask out, all registered).
// Latency: chan_req first high 2 cycles after start; readout_done worst case NUM_CHAN*(TIMEOUT_CYCLES+1)+2.
module readout_sequencer #(
  parameter int NUM_CHAN       = 5,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FILL_W         = 24
) (
  input logic              clk,
  input logic              reset,
  readout_sequencer_if.slave bus
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CHAN-1:0] chan_req_q, chan_req_d;
  logic [NUM_CHAN-1:0] pending_q, pending_d;
  logic [NUM_CHAN-1:0] err_mask_q, err_mask_d;
  logic [2:0]          cur_chan_q, cur_chan_d;
  logic [FILL_W-1:0]   cur_fill_q, cur_fill_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                busy_q, busy_d;
  logic                readout_done_q, readout_done_d;

  logic [NUM_CHAN-1:0] lowest_bit;
  logic [2:0]          lowest_idx;
  logic                done_hit;
  logic                timed_out;
  logic [NUM_CHAN-1:0] pending_left;

  // Lowest pending channel, both as a one-hot grant and as an index.
  always_comb begin
    lowest_bit = pending_q & (~pending_q + NUM_CHAN'(1));
    lowest_idx = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lowest_idx = 3'(i);
      end
    end
  end

  // chan_req_q is one-hot on cur_chan while waiting, so masking with it
  // selects chan_done[cur_chan] and ignores every other channel's done bit.
  assign done_hit     = |(bus.chan_done & chan_req_q);
  assign timed_out    = (timer_q == TIMER_LAST);
  assign pending_left = pending_q & ~chan_req_q;

  always_comb begin
    state_d        = state_q;
    chan_req_d     = chan_req_q;
    pending_d      = pending_q;
    err_mask_d     = err_mask_q;
    cur_chan_d     = cur_chan_q;
    cur_fill_d     = cur_fill_q;
    timer_d        = timer_q;
    readout_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // busy_q also covers the readout_done cycle, so a start arriving
        // together with the completion pulse is dropped, not queued.
        if (bus.start && !busy_q) begin
          cur_fill_d = bus.fill_num;
          pending_d  = bus.chan_en;
          err_mask_d = '0;
          state_d    = (bus.chan_en != '0) ? SELECT : FINISH;
        end
      end

      SELECT: begin
        cur_chan_d = lowest_idx;
        chan_req_d = lowest_bit;
        timer_d    = '0;
        state_d    = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (done_hit || timed_out) begin
          chan_req_d = '0;
          pending_d  = pending_left;
          // A done arriving in the timeout cycle still counts as success.
          if (!done_hit) begin
            err_mask_d = err_mask_q | chan_req_q;
          end
          state_d = (pending_left != '0) ? SELECT : FINISH;
        end else begin
          // timed_out is false here, so the increment never wraps.
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      FINISH: begin
        readout_done_d = 1'b1;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered busy tracks the next state and stays up through the
    // readout_done pulse cycle, dropping the cycle after it.
    busy_d = (state_d != IDLE) || (state_q == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      chan_req_q     <= '0;
      pending_q      <= '0;
      err_mask_q     <= '0;
      cur_chan_q     <= '0;
      cur_fill_q     <= '0;
      timer_q        <= '0;
      busy_q         <= 1'b0;
      readout_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      chan_req_q     <= chan_req_d;
      pending_q      <= pending_d;
      err_mask_q     <= err_mask_d;
      cur_chan_q     <= cur_chan_d;
      cur_fill_q     <= cur_fill_d;
      timer_q        <= timer_d;
      busy_q         <= busy_d;
      readout_done_q <= readout_done_d;
    end
  end

  assign bus.chan_req     = chan_req_q;
  assign bus.cur_chan     = cur_chan_q;
  assign bus.cur_fill     = cur_fill_q;
  assign bus.busy         = busy_q;
  assign bus.readout_done = readout_done_q;
  assign bus.err_mask     = err_mask_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer (NUM_CHAN=5, TIMEOUT_CYCLES=16, FILL_W=24).
// Channel engines are modelled inside tick(): channel i raises done when its grant reaches age resp_age[i].
// Grant order, grant lengths, gaps, latencies and status outputs are compared against hand-derived values.
module tb_readout_sequencer;

  localparam int NC = 5;
  localparam int TO = 16;
  localparam int FW = 24;

  logic clk;
  logic reset;

  readout_sequencer_if #(.NUM_CHAN(NC), .FILL_W(FW)) bus ();

  readout_sequencer #(
    .NUM_CHAN(NC),
    .TIMEOUT_CYCLES(TO),
    .FILL_W(FW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Channel model and activity log
  int            cyc = 0;
  int            start_cyc = 0;
  int            age[NC];
  int            resp_age[NC];
  logic [NC-1:0] force_done = '0;
  logic [NC-1:0] prev_req = '0;
  logic [NC-1:0] grant_q[$];
  int            chan_q[$];
  int            len_q[$];
  int            gap_q[$];
  int            req_len = 0;
  int            gap_cnt = 0;
  bit            seen_grant = 0;
  int            done_cnt = 0;
  int            onehot_err = 0;
  int            exp_req[8];
  int            exp_chan[8];
  int            exp_len[8];
  int            lat;
  logic          busy_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: advance past the edge, then log outputs and update channel responses.
  task automatic tick();
    logic [NC-1:0] req;
    logic [NC-1:0] resp;
    @(posedge clk);
    #1;
    cyc++;
    req = bus.chan_req;
    if ($countones(req) > 1) onehot_err++;
    if (req != '0 && prev_req == '0) begin
      grant_q.push_back(req);
      chan_q.push_back(int'(bus.cur_chan));
      if (seen_grant) gap_q.push_back(gap_cnt);
      seen_grant = 1;
      gap_cnt = 0;
      req_len = 0;
    end
    if (req != '0) req_len++;
    if (req == '0 && prev_req != '0) len_q.push_back(req_len);
    if (req == '0 && seen_grant) gap_cnt++;
    if (bus.readout_done) done_cnt++;
    prev_req = req;
    resp = '0;
    for (int i = 0; i < NC; i++) begin
      age[i] = req[i] ? age[i] + 1 : 0;
      if (resp_age[i] != 0 && age[i] == resp_age[i]) resp[i] = 1'b1;
    end
    bus.chan_done = resp | force_done;
  endtask

  task automatic clear_log();
    grant_q.delete();
    chan_q.delete();
    len_q.delete();
    gap_q.delete();
    seen_grant = 0;
    gap_cnt = 0;
    req_len = 0;
    done_cnt = 0;
    onehot_err = 0;
  endtask

  task automatic do_start(input logic [FW-1:0] fill, input logic [NC-1:0] en);
    clear_log();
    start_cyc = cyc;
    bus.fill_num = fill;
    bus.chan_en = en;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int latency);
    latency = -1;
    busy_at_done = 1'b0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (bus.readout_done) begin
        latency = cyc - start_cyc;
        busy_at_done = bus.busy;
        break;
      end
    end
  endtask

  task automatic check_seq(input string tag, input int n);
    check({tag, "_ngrant"}, grant_q.size(), n);
    check({tag, "_nlen"}, len_q.size(), n);
    for (int i = 0; i < n && i < grant_q.size(); i++) begin
      check($sformatf("%s_req%0d", tag, i), grant_q[i], exp_req[i]);
      check($sformatf("%s_chan%0d", tag, i), chan_q[i], exp_chan[i]);
      if (i < len_q.size()) check($sformatf("%s_len%0d", tag, i), len_q[i], exp_len[i]);
    end
    check({tag, "_ngap"}, gap_q.size(), (n > 0) ? n - 1 : 0);
    for (int i = 0; i < gap_q.size(); i++) begin
      check($sformatf("%s_gap%0d", tag, i), gap_q[i], 1);
    end
    check({tag, "_onehot"}, onehot_err, 0);
  endtask

  // Completion: single pulse, busy high during it, low the cycle after.
  task automatic check_end(input string tag, input int exp_lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_at_done"}, busy_at_done, 1'b1);
    tick();
    check({tag, "_busy_after"}, bus.busy, 1'b0);
    check({tag, "_done_low"}, bus.readout_done, 1'b0);
    tick();
    tick();
    check({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.fill_num = '0;
    bus.chan_en = '0;
    bus.chan_done = '0;
    for (int i = 0; i < NC; i++) begin
      age[i] = 0;
      resp_age[i] = 0;
    end

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_chan_req", bus.chan_req, 0);
    check("rst_cur_chan", bus.cur_chan, 0);
    check("rst_cur_fill", bus.cur_fill, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.readout_done, 0);
    check("rst_err", bus.err_mask, 0);

    // All channels enabled, each answers 3 cycles after its grant (4-cycle grant).
    // A second start while busy must be ignored.
    for (int i = 0; i < NC; i++) resp_age[i] = 4;
    do_start(24'h000123, 5'b11111);
    check("all_busy_c1", bus.busy, 1'b1);
    check("all_req_c1", bus.chan_req, 0);
    tick();
    check("all_req_c2", bus.chan_req, 5'b00001);
    tick();
    bus.fill_num = 24'hABCDEF;
    bus.chan_en = 5'b00000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(200, lat);
    exp_req  = '{1, 2, 4, 8, 16, 0, 0, 0};
    exp_chan = '{0, 1, 2, 3, 4, 0, 0, 0};
    exp_len  = '{4, 4, 4, 4, 4, 0, 0, 0};
    check_seq("all", 5);
    check("all_cur_fill", bus.cur_fill, 24'h000123);
    check("all_err", bus.err_mask, 0);
    check_end("all", 27);
    check("all_cur_fill_idle", bus.cur_fill, 24'h000123);

    // Sparse mask: channels 2 and 4 only
    do_start(24'h00BEEF, 5'b10100);
    wait_done(200, lat);
    exp_req  = '{4, 16, 0, 0, 0, 0, 0, 0};
    exp_chan = '{2, 4, 0, 0, 0, 0, 0, 0};
    exp_len  = '{4, 4, 0, 0, 0, 0, 0, 0};
    check_seq("sparse", 2);
    check("sparse_cur_fill", bus.cur_fill, 24'h00BEEF);
    check_end("sparse", 12);

    // Empty mask: straight to completion, no grant
    do_start(24'h000042, 5'b00000);
    wait_done(50, lat);
    check_seq("empty", 0);
    check("empty_cur_fill", bus.cur_fill, 24'h000042);
    check_end("empty", 2);

    // Timeout on channel 0, channel 1 normal; channel 3's done held high is ignored
    resp_age[0] = 0;
    force_done = 5'b01000;
    do_start(24'h0A0B0C, 5'b00011);
    wait_done(200, lat);
    exp_req  = '{1, 2, 0, 0, 0, 0, 0, 0};
    exp_chan = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_len  = '{16, 4, 0, 0, 0, 0, 0, 0};
    check_seq("tmo", 2);
    check("tmo_err", bus.err_mask, 5'b00001);
    check_end("tmo", 24);
    check("tmo_err_hold", bus.err_mask, 5'b00001);
    force_done = '0;

    // Done in the same cycle as the timeout: success, err_mask cleared by the new start
    resp_age[0] = 16;
    do_start(24'h0C0FFE, 5'b00001);
    wait_done(200, lat);
    exp_req  = '{1, 0, 0, 0, 0, 0, 0, 0};
    exp_chan = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_len  = '{16, 0, 0, 0, 0, 0, 0, 0};
    check_seq("coinc", 1);
    check("coinc_err", bus.err_mask, 0);
    check_end("coinc", 19);

    // Reset while channel 2 holds the grant
    resp_age[0] = 4;
    resp_age[2] = 0;
    do_start(24'h777777, 5'b00100);
    tick();
    check("rmid_req", bus.chan_req, 5'b00100);
    check("rmid_cur_chan", bus.cur_chan, 2);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_chan_req", bus.chan_req, 0);
    check("rmid_cur_chan0", bus.cur_chan, 0);
    check("rmid_cur_fill", bus.cur_fill, 0);
    check("rmid_busy", bus.busy, 0);
    check("rmid_err", bus.err_mask, 0);
    for (int i = 0; i < 20; i++) tick();
    check("rmid_no_done", done_cnt, 0);
    check("rmid_req_idle", bus.chan_req, 0);

    // Normal operation after the mid-grant reset
    resp_age[2] = 4;
    do_start(24'h55AA55, 5'b00110);
    wait_done(200, lat);
    exp_req  = '{2, 4, 0, 0, 0, 0, 0, 0};
    exp_chan = '{1, 2, 0, 0, 0, 0, 0, 0};
    exp_len  = '{4, 4, 0, 0, 0, 0, 0, 0};
    check_seq("after", 2);
    check("after_cur_fill", bus.cur_fill, 24'h55AA55);
    check("after_err", bus.err_mask, 0);
    check_end("after", 12);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Sequences per-channel readout after a fill has been digitised and its fill number stored. Sits between the trigger manager and the channel readout engines.
- On `start`, grants readout to each enabled channel in turn, lowest index first, one at a time. Each channel is handed off with a req/done handshake and guarded by a per-channel timeout.
- Emits a single `readout_done` pulse when every enabled channel has finished or timed out. The trigger manager consumes this pulse as its channel-readout-done input.

Parameters:
- NUM_CHAN, 5, number of channels (1..8).
- TIMEOUT_CYCLES, 4096, maximum cycles a channel may hold its grant (2..65535).
- FILL_W, 24, fill-number width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: fill stored, begin readout
- fill_num  in  FILL_W  fill number, sampled with start
- chan_en  in  NUM_CHAN  enabled-channel mask, sampled with start
- chan_done  in  NUM_CHAN  per-channel readout complete (level or pulse)
- chan_req  out  NUM_CHAN  one-hot readout grant, registered
- cur_chan  out  3  index of the granted or last-granted channel
- cur_fill  out  FILL_W  latched fill number
- busy  out  1  high whenever state != IDLE
- readout_done  out  1  one-cycle completion pulse
- err_mask  out  NUM_CHAN  channels that timed out during the current or last fill

Behaviour:
- Reset values: chan_req=0, cur_chan=0, cur_fill=0, busy=0, readout_done=0, err_mask=0, timer=0, pending=0, state=IDLE.
- Reset has priority at every cycle. Reset mid-operation drops chan_req immediately at the next edge; no readout_done is issued.
- States: IDLE, SELECT, WAIT_DONE, FINISH. All outputs are registered.
- IDLE:
  - On start=1: latch cur_fill<=fill_num, pending<=chan_en, err_mask<=0.
  - Next state is SELECT if chan_en!=0, else FINISH.
- SELECT:
  - Pick lowest set bit i of pending; cur_chan<=i; chan_req<=(1<<i); timer<=0.
  - Go to WAIT_DONE. chan_req is therefore first high 2 cycles after the start edge.
- WAIT_DONE:
  - Only chan_done[cur_chan] is observed. Done bits of other channels are ignored.
  - If chan_done[cur_chan]=1: chan_req<=0, clear pending[cur_chan].
  - Else if timer==TIMEOUT_CYCLES-1: chan_req<=0, set err_mask[cur_chan], clear pending[cur_chan].
  - Else timer<=timer+1 and chan_req holds.
  - If done and timeout coincide, done wins and err_mask is not set.
  - After clearing: go to SELECT if the remaining pending!=0, else FINISH.
- Gap between channels: chan_req drops for exactly 1 cycle (the SELECT cycle) before the next grant.
- FINISH: readout_done=1 for exactly one cycle, then IDLE.
- busy is deasserted in the cycle after the readout_done pulse.
- start while busy=1 is ignored: no relatch, no queueing.
- chan_en bits at or above NUM_CHAN do not exist. cur_chan width is fixed at 3; with NUM_CHAN<8, the unused index values never occur.
- Timer width is clog2(TIMEOUT_CYCLES). The timer saturates and never wraps.
- Worst-case latency from start to readout_done is NUM_CHAN*(TIMEOUT_CYCLES+1)+2 cycles.
- err_mask holds its value until the next accepted start.

Test Plan:
- All enabled, fast channels: reset, start with fill_num=0x000123, chan_en=5'b11111; each channel raises done 3 cycles after its req. Expected:
  - chan_req walks 00001→00010→00100→01000→10000 with 1-cycle gaps.
  - readout_done pulses once; cur_fill=0x000123; err_mask=0.
- Sparse mask: chan_en=5'b10100. Expected: grants only 00100 then 10000; cur_chan values 2 then 4; one readout_done.
- Empty mask: chan_en=0. Expected: readout_done 2 cycles after start; chan_req never asserted.
- Timeout: chan_en=5'b00011, TIMEOUT_CYCLES=16, channel 0 never responds, channel 1 responds. Expected:
  - chan_req[0] high for exactly 16 cycles, then err_mask=5'b00001.
  - Channel 1 is serviced normally; readout_done pulses once.
- Ignored inputs:
  - A second start while busy is ignored; cur_fill stays unchanged.
  - chan_done[3] asserted while channel 1 is granted has no effect.
  - done coinciding with the timeout cycle leaves the err_mask bit clear.
- Reset mid-grant: assert reset while chan_req=5'b00100. Expected: next cycle all outputs are 0 and state=IDLE. A subsequent start works normally.
